// File: rtl/wash_cycle_timer_if.sv
// Controller <-> phase timer bundle: actuator levels in, timer-done levels out.
// master = washer controller side, slave = timer side.
interface wash_cycle_timer_if;
    logic       timer_clear;
    logic       water_fill;
    logic       agitator;
    logic       motor;
    logic       pump;
    logic       speed;
    logic       door;
    logic       td;
    logic       tf;
    logic       tr;
    logic       ts;
    logic       tw;
    logic [2:0] phase;

    modport master (
        output timer_clear, water_fill, agitator,
        output motor, pump, speed, door,
        input  td, tf, tr, ts, tw, phase
    );

    modport slave (
        input  timer_clear, water_fill, agitator,
        input  motor, pump, speed, door,
        output td, tf, tr, ts, tw, phase
    );
endinterface

// File: rtl/wash_cycle_timer.sv
// Wash-cycle phase timer: infers the phase from actuator levels and raises
// that phase's done level once it has run its programmed number of cycles.
module wash_cycle_timer #(
    parameter int FILL_CYC  = 8,
    parameter int WASH_CYC  = 16,
    parameter int RINSE_CYC = 12,
    parameter int SPIN_CYC  = 10,
    parameter int DRAIN_CYC = 6,
    parameter int CNT_W     = 16
) (
    input logic              clk,
    input logic              reset,
    wash_cycle_timer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        DRAIN = 3'd2,
        SPIN  = 3'd3,
        RINSE = 3'd4,
        WASH  = 3'd5
    } phase_t;

    localparam logic [CNT_W-1:0] FILL_D  = CNT_W'(FILL_CYC);
    localparam logic [CNT_W-1:0] WASH_D  = CNT_W'(WASH_CYC);
    localparam logic [CNT_W-1:0] RINSE_D = CNT_W'(RINSE_CYC);
    localparam logic [CNT_W-1:0] SPIN_D  = CNT_W'(SPIN_CYC);
    localparam logic [CNT_W-1:0] DRAIN_D = CNT_W'(DRAIN_CYC);

    phase_t           dec;
    phase_t           phase_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dur;
    logic             at_dur;

    // Overlapping actuator combinations resolve by fixed priority.
    always_comb begin
        dec = IDLE;
        if (bus.water_fill)
            dec = FILL;
        else if (bus.pump && !bus.motor)
            dec = DRAIN;
        else if (bus.motor && bus.speed && !bus.agitator)
            dec = SPIN;
        else if (bus.agitator && bus.speed)
            dec = RINSE;
        else if (bus.agitator && !bus.speed)
            dec = WASH;
    end

    always_comb begin
        dur = '0;
        unique case (phase_q)
            FILL:    dur = FILL_D;
            DRAIN:   dur = DRAIN_D;
            SPIN:    dur = SPIN_D;
            RINSE:   dur = RINSE_D;
            WASH:    dur = WASH_D;
            default: dur = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= IDLE;
            cnt     <= '0;
        end else if (bus.timer_clear || dec != phase_q) begin
            phase_q <= dec;
            cnt     <= '0;
        end else if (phase_q != IDLE && !bus.door && cnt < dur) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Dones decode straight from state so reset clears them immediately.
    assign at_dur    = (phase_q != IDLE) && (cnt == dur);
    assign bus.tf    = at_dur && (phase_q == FILL);
    assign bus.td    = at_dur && (phase_q == DRAIN);
    assign bus.ts    = at_dur && (phase_q == SPIN);
    assign bus.tr    = at_dur && (phase_q == RINSE);
    assign bus.tw    = at_dur && (phase_q == WASH);
    assign bus.phase = phase_q;

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Bench for wash_cycle_timer: directed phase scenarios plus randomized
// actuator/door/clear/reset traffic against a behavioural model.
module tb_wash_cycle_timer;

    localparam int F = 4;
    localparam int W = 6;
    localparam int R = 5;
    localparam int S = 3;
    localparam int D = 2;

    localparam logic [4:0] M_TD = 5'b10000;
    localparam logic [4:0] M_TF = 5'b01000;
    localparam logic [4:0] M_TR = 5'b00100;
    localparam logic [4:0] M_TS = 5'b00010;
    localparam logic [4:0] M_TW = 5'b00001;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   m_ph = 0;
    int   m_el = 0;
    logic [4:0] dn;

    wash_cycle_timer_if bus ();

    wash_cycle_timer #(
        .FILL_CYC (F),
        .WASH_CYC (W),
        .RINSE_CYC(R),
        .SPIN_CYC (S),
        .DRAIN_CYC(D),
        .CNT_W    (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign dn = {bus.td, bus.tf, bus.tr, bus.ts, bus.tw};

    always #5 clk = ~clk;

    function automatic int ref_decode();
        if (bus.water_fill) return 1;
        if (bus.pump && !bus.motor) return 2;
        if (bus.motor && bus.speed && !bus.agitator) return 3;
        if (bus.agitator && bus.speed) return 4;
        if (bus.agitator && !bus.speed) return 5;
        return 0;
    endfunction

    function automatic int ref_dur(input int p);
        case (p)
            1: return F;
            2: return D;
            3: return S;
            4: return R;
            5: return W;
            default: return 0;
        endcase
    endfunction

    function automatic logic [4:0] ref_done();
        if (m_ph == 0 || m_el < ref_dur(m_ph)) return 5'b0;
        case (m_ph)
            1: return M_TF;
            2: return M_TD;
            3: return M_TS;
            4: return M_TR;
            default: return M_TW;
        endcase
    endfunction

    // Model tracks the phase and the door-closed time spent in it.
    task automatic step();
        int d;
        @(posedge clk);
        if (!reset) begin
            d = ref_decode();
            if (bus.timer_clear || d != m_ph) begin
                m_ph = d;
                m_el = 0;
            end else if (!bus.door && m_ph != 0) begin
                m_el = (m_el + 1 > ref_dur(m_ph)) ? ref_dur(m_ph) : m_el + 1;
            end
        end
        #1;
    endtask

    task automatic set_in(input logic [4:0] p);
        {bus.water_fill, bus.agitator, bus.motor, bus.pump, bus.speed} = p;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(5'b0);
        bus.door = 1'b0;
        bus.timer_clear = 1'b0;
        m_ph = 0;
        m_el = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(5'b10000);
        bus.door = 1'b0;
        bus.timer_clear = 1'b0;
        #1;
        checks++;
        if (bus.phase !== 3'd0 || dn !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: phase=%0d dn=%b want 0/00000", bus.phase, dn);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.phase !== 3'd0 || dn !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold: phase=%0d dn=%b want 0/00000", bus.phase, dn);
        end
        do_reset();
    endtask

    task automatic test_fill();
        do_reset();
        set_in(5'b10000);
        for (int i = 0; i <= 6; i++) begin
            step();
            checks++;
            if (bus.phase !== 3'd1 || dn !== ((i >= F) ? M_TF : 5'b0)) begin
                errors++;
                $display("FAIL fill edge%0d: phase=%0d dn=%b want 1/%b",
                         i, bus.phase, dn, (i >= F) ? M_TF : 5'b0);
            end
        end
    endtask

    task automatic test_sequence();
        logic [4:0] pat [5] = '{5'b10000, 5'b01000, 5'b01001, 5'b00101, 5'b00010};
        logic [2:0] ph  [5] = '{3'd1, 3'd5, 3'd4, 3'd3, 3'd2};
        int         dr  [5] = '{F, W, R, S, D};
        logic [4:0] msk [5] = '{M_TF, M_TW, M_TR, M_TS, M_TD};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in(pat[k]);
            step();
            checks++;
            if (bus.phase !== ph[k] || dn !== 5'b0) begin
                errors++;
                $display("FAIL seq%0d entry: phase=%0d dn=%b want %0d/00000",
                         k, bus.phase, dn, ph[k]);
            end
            for (int j = 1; j <= dr[k]; j++) begin
                step();
                checks++;
                if (dn !== ((j == dr[k]) ? msk[k] : 5'b0)) begin
                    errors++;
                    $display("FAIL seq%0d edge%0d: dn=%b want %b",
                             k, j, dn, (j == dr[k]) ? msk[k] : 5'b0);
                end
            end
        end
    endtask

    task automatic test_door();
        do_reset();
        set_in(5'b01000);
        step();
        step();
        step();
        bus.door = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.door = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step();
            checks++;
            if (dn !== ((j == 4) ? M_TW : 5'b0)) begin
                errors++;
                $display("FAIL door_resume edge%0d: dn=%b want %b",
                         j, dn, (j == 4) ? M_TW : 5'b0);
            end
        end
        bus.door = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (dn !== M_TW || bus.phase !== 3'd5) begin
            errors++;
            $display("FAIL door_after_done: phase=%0d dn=%b want 5/%b", bus.phase, dn, M_TW);
        end
        bus.door = 1'b0;
    endtask

    task automatic test_clear();
        do_reset();
        set_in(5'b01001);
        for (int i = 0; i < 5; i++) step();
        bus.timer_clear = 1'b1;
        step();
        bus.timer_clear = 1'b0;
        checks++;
        if (bus.phase !== 3'd4 || dn !== 5'b0) begin
            errors++;
            $display("FAIL clear_now: phase=%0d dn=%b want 4/00000", bus.phase, dn);
        end
        for (int j = 1; j <= R; j++) begin
            step();
            checks++;
            if (dn !== ((j == R) ? M_TR : 5'b0)) begin
                errors++;
                $display("FAIL clear_recount edge%0d: dn=%b want %b",
                         j, dn, (j == R) ? M_TR : 5'b0);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(5'b00101);
        for (int i = 0; i <= S; i++) step();
        checks++;
        if (dn !== M_TS) begin
            errors++;
            $display("FAIL spin_done: dn=%b want %b", dn, M_TS);
        end
        #2;
        reset = 1'b1;
        m_ph = 0;
        m_el = 0;
        #1;
        checks++;
        if (bus.phase !== 3'd0 || dn !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: phase=%0d dn=%b want 0/00000", bus.phase, dn);
        end
        reset = 1'b0;
        for (int j = 0; j <= S; j++) begin
            step();
            checks++;
            if (bus.phase !== 3'd3 || dn !== ((j == S) ? M_TS : 5'b0)) begin
                errors++;
                $display("FAIL post_reset edge%0d: phase=%0d dn=%b", j, bus.phase, dn);
            end
        end
    endtask

    task automatic test_priority();
        do_reset();
        set_in(5'b10010);
        step();
        checks++;
        if (bus.phase !== 3'd1) begin
            errors++;
            $display("FAIL prio_fill: phase=%0d want 1", bus.phase);
        end
        set_in(5'b00010);
        for (int j = 0; j <= D; j++) begin
            step();
            checks++;
            if (bus.phase !== 3'd2 || dn !== ((j == D) ? M_TD : 5'b0)) begin
                errors++;
                $display("FAIL prio_drain edge%0d: phase=%0d dn=%b", j, bus.phase, dn);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) set_in(5'($urandom_range(0, 31)));
            bus.door = ($urandom_range(0, 4) == 0);
            bus.timer_clear = ($urandom_range(0, 24) == 0);
            step();
            checks++;
            if (bus.phase !== 3'(m_ph) || dn !== ref_done()) begin
                errors++;
                $display("FAIL random c%0d: phase=%0d dn=%b want %0d/%b",
                         c, bus.phase, dn, m_ph, ref_done());
            end
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                m_ph = 0;
                m_el = 0;
                #1;
                checks++;
                if (bus.phase !== 3'd0 || dn !== 5'b0) begin
                    errors++;
                    $display("FAIL random_reset c%0d: phase=%0d dn=%b", c, bus.phase, dn);
                end
                reset = 1'b0;
            end
        end
        bus.door = 1'b0;
        bus.timer_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_sequence();
        test_door();
        test_clear();
        test_reset_mid();
        test_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
